// File: rtl/line_follow_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : line_follow_pkg
// Description : Shared types and motor command codes for the line-following
//               motor controller.
// Revision    : 1.0 - initial release
// ============================================================================
package line_follow_pkg;

   // FSM state codes, also presented on the state output
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FOLLOW = 3'd1,
      SEARCH = 3'd2,
      OBST   = 3'd3,
      STOP   = 3'd4
   } lf_state_e;

   // Direction of the most recent turn, used to pick the search pivot
   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } lf_dir_e;

   // H-bridge commands: [3:2] left motor, [1:0] right motor
   localparam logic [3:0] MOT_COAST   = 4'b0000;
   localparam logic [3:0] MOT_FWD     = 4'b0110;
   localparam logic [3:0] MOT_SOFT_L  = 4'b0010;
   localparam logic [3:0] MOT_SOFT_R  = 4'b0100;
   localparam logic [3:0] MOT_PIVOT_L = 4'b1010;
   localparam logic [3:0] MOT_PIVOT_R = 4'b0101;

endpackage
`default_nettype wire

// File: rtl/line_follow_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : line_follow_ctrl_if
// Description : Sensor, configuration and motor-command bundle between the
//               rover pins and the line-following controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_follow_ctrl_if #(
   parameter int NUM_SENS = 3,
   parameter int PWM_BITS = 8
);
   logic [NUM_SENS-1:0] induct;
   logic                proxim;
   logic                enable;
   logic [PWM_BITS-1:0] duty_fwd;
   logic [PWM_BITS-1:0] duty_turn;
   logic [3:0]          motor_in;
   logic [2:0]          state;
   logic                lost;

   // Pin / environment side
   modport master (
      output induct, proxim, enable, duty_fwd, duty_turn,
      input  motor_in, state, lost
   );

   // Controller side
   modport slave (
      input  induct, proxim, enable, duty_fwd, duty_turn,
      output motor_in, state, lost
   );
endinterface
`default_nettype wire

// File: rtl/line_follow_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce
// Description : 2-flop synchroniser followed by a stability filter. The
//               output follows the synced input only after it has differed
//               from the output for DEB_CYCLES consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);
   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic          sync1_q, sync2_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Count consecutive mismatches; any agreement restarts the count
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser and filter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = filt_q;
endmodule
`default_nettype wire

// File: rtl/line_follow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_follow_ctrl
// Description : Clocked line-following controller: debounced sensors,
//               proportional steering, obstacle hold, timed line search and
//               PWM-gated H-bridge command.
// Revision    : 1.0 - initial release
// ============================================================================
module line_follow_ctrl
   import line_follow_pkg::*;
#(
   parameter int NUM_SENS     = 3,
   parameter int DEB_CYCLES   = 4,
   parameter int PWM_BITS     = 8,
   parameter int LOST_CYCLES  = 1000,
   parameter int CLEAR_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   line_follow_ctrl_if.slave bus
);
   localparam int C   = (NUM_SENS - 1) / 2;
   localparam int SCW = $clog2(LOST_CYCLES + 1);
   localparam int CCW = $clog2(CLEAR_CYCLES + 1);

   logic [NUM_SENS:0]   raw_in, deb_in;
   logic [NUM_SENS-1:0] deb_induct;
   logic                deb_prox;

   assign raw_in = {bus.proxim, bus.induct};

   generate
      for (genvar i = 0; i <= NUM_SENS; i++) begin : g_deb
         input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (raw_in[i]),
            .dout (deb_in[i])
         );
      end
   endgenerate

   assign deb_induct = deb_in[NUM_SENS-1:0];
   assign deb_prox   = deb_in[NUM_SENS];

   logic                l_any, r_any, c_on, line_lost;
   logic                turn_valid, steer_pivot;
   lf_dir_e             turn_dir;
   logic [3:0]          steer_cmd;

   lf_state_e           state_q, state_d;
   lf_dir_e             last_dir_q, last_dir_d;
   logic [SCW-1:0]      srch_cnt_q, srch_cnt_d;
   logic [CCW-1:0]      clr_cnt_q, clr_cnt_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [3:0]          motor_q, motor_d, mot_cmd;
   logic [PWM_BITS-1:0] mot_duty;
   logic [2:0]          state_out_q, state_out_d;
   logic                lost_q, lost_d;

   // Classify the debounced sensor row into a steering command
   always_comb begin
      l_any       = |deb_induct[NUM_SENS-1:C+1];
      r_any       = |deb_induct[C-1:0];
      c_on        = deb_induct[C];
      line_lost   = ~|deb_induct;
      turn_valid  = 1'b0;
      turn_dir    = DIR_LEFT;
      steer_pivot = 1'b0;
      steer_cmd   = MOT_COAST;
      if (l_any && r_any) begin
         steer_cmd = MOT_FWD;
      end else if (l_any) begin
         turn_valid  = 1'b1;
         turn_dir    = DIR_LEFT;
         steer_pivot = deb_induct[NUM_SENS-1] && !c_on;
         steer_cmd   = steer_pivot ? MOT_PIVOT_L : MOT_SOFT_L;
      end else if (r_any) begin
         turn_valid  = 1'b1;
         turn_dir    = DIR_RIGHT;
         steer_pivot = deb_induct[0] && !c_on;
         steer_cmd   = steer_pivot ? MOT_PIVOT_R : MOT_SOFT_R;
      end else if (c_on) begin
         steer_cmd = MOT_FWD;
      end
   end

   // Next-state logic; enable and obstacle override each state's own exits
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.enable) state_d = FOLLOW;
         FOLLOW:  if (line_lost) state_d = SEARCH;
         SEARCH: begin
            if (!line_lost) begin
               state_d = FOLLOW;
            end else if (srch_cnt_q == SCW'(LOST_CYCLES - 1)) begin
               state_d = STOP;
            end
         end
         OBST:    if (!deb_prox && clr_cnt_q == CCW'(CLEAR_CYCLES - 1)) state_d = FOLLOW;
         STOP:    state_d = STOP;
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && state_q != STOP && deb_prox) begin
         state_d = OBST;
      end
      if (!bus.enable) begin
         state_d = IDLE;
      end

      // Counters run only while staying in their state, so entry clears them
      srch_cnt_d = (state_q == SEARCH && state_d == SEARCH) ? srch_cnt_q + 1'b1 : '0;
      clr_cnt_d  = (state_q == OBST && state_d == OBST && !deb_prox) ? clr_cnt_q + 1'b1 : '0;
      last_dir_d = (state_q == FOLLOW && turn_valid) ? turn_dir : last_dir_q;
      pwm_d      = pwm_q + 1'b1;
   end

   // Registered outputs: command for the current state, gated by PWM
   always_comb begin
      mot_cmd  = MOT_COAST;
      mot_duty = '0;
      case (state_q)
         FOLLOW: begin
            mot_cmd  = steer_cmd;
            mot_duty = steer_pivot ? bus.duty_turn : bus.duty_fwd;
         end
         SEARCH: begin
            mot_cmd  = (last_dir_q == DIR_LEFT) ? MOT_PIVOT_L : MOT_PIVOT_R;
            mot_duty = bus.duty_turn;
         end
         default: ;
      endcase
      motor_d     = (pwm_q < mot_duty) ? mot_cmd : MOT_COAST;
      state_out_d = state_q;
      lost_d      = (state_q == SEARCH) || (state_q == STOP);
   end

   // All controller state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_dir_q  <= DIR_LEFT;
         srch_cnt_q  <= '0;
         clr_cnt_q   <= '0;
         pwm_q       <= '0;
         motor_q     <= MOT_COAST;
         state_out_q <= 3'd0;
         lost_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_dir_q  <= last_dir_d;
         srch_cnt_q  <= srch_cnt_d;
         clr_cnt_q   <= clr_cnt_d;
         pwm_q       <= pwm_d;
         motor_q     <= motor_d;
         state_out_q <= state_out_d;
         lost_q      <= lost_d;
      end
   end

   assign bus.motor_in = motor_q;
   assign bus.state    = state_out_q;
   assign bus.lost     = lost_q;
endmodule
`default_nettype wire
